// File: rtl/alu_seq_unit.sv
// Execute-stage ALU: single-cycle logic/arithmetic plus
// iterative 32-step unsigned MULTU/DIVU into HI/LO.
module alu_seq_unit #(
  parameter int WIDTH = 32
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic             start,
  input  logic [3:0]       ALUOp,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO,
  output logic             busy,
  output logic             done
);

  localparam int CW = $clog2(WIDTH);

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_AND  = 4'b0010;
  localparam logic [3:0] OP_OR   = 4'b0011;
  localparam logic [3:0] OP_XOR  = 4'b0100;
  localparam logic [3:0] OP_SLT  = 4'b0101;
  localparam logic [3:0] OP_SLL  = 4'b0110;
  localparam logic [3:0] OP_MULU = 4'b0111;
  localparam logic [3:0] OP_DIVU = 4'b1000;

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
    S_DIV
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [WIDTH-1:0] r_result;
  logic             r_zero;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic             r_done;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_b;

  logic [WIDTH-1:0] w_alu;
  logic             w_last;
  logic             w_div0;
  logic [WIDTH:0]   w_msum;
  logic [WIDTH-1:0] w_mhi;
  logic [WIDTH-1:0] w_mlo;
  logic [WIDTH:0]   w_rs;
  logic [WIDTH:0]   w_diff;
  logic             w_ge;
  logic [WIDTH-1:0] w_drem;
  logic [WIDTH-1:0] w_dq;

  assign w_last = (r_cnt == CW'(WIDTH - 1));
  assign w_div0 = (B == '0);

  always_comb begin
    w_alu = '0;
    case (ALUOp)
      OP_ADD: w_alu = A + B;
      OP_SUB: w_alu = A - B;
      OP_AND: w_alu = A & B;
      OP_OR:  w_alu = A | B;
      OP_XOR: w_alu = A ^ B;
      OP_SLT: w_alu = WIDTH'($signed(A) < $signed(B));
      OP_SLL: w_alu = B << A[CW-1:0];
      default: w_alu = '0;
    endcase
  end

  // Shift-add: {r_acc,r_q} shifts right, adding multiplicand on LSB.
  assign w_msum = {1'b0, r_acc} + (r_q[0] ? {1'b0, r_b} : '0);
  assign w_mhi  = w_msum[WIDTH:1];
  assign w_mlo  = {w_msum[0], r_q[WIDTH-1:1]};

  // Restoring division: partial remainder is always < divisor.
  assign w_rs   = {r_acc, r_q[WIDTH-1]};
  assign w_ge   = (w_rs >= {1'b0, r_b});
  assign w_diff = w_rs - {1'b0, r_b};
  assign w_drem = w_ge ? w_diff[WIDTH-1:0] : w_rs[WIDTH-1:0];
  assign w_dq   = {r_q[WIDTH-2:0], w_ge};

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (start && ALUOp == OP_MULU) begin
          w_next = S_MUL;
        end else if (start && ALUOp == OP_DIVU && !w_div0) begin
          w_next = S_DIV;
        end
      end
      S_MUL, S_DIV: begin
        if (w_last) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (Reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      r_result <= '0;
      r_zero   <= 1'b1;
      r_hi     <= '0;
      r_lo     <= '0;
      r_done   <= 1'b0;
      r_cnt    <= '0;
      r_acc    <= '0;
      r_q      <= '0;
      r_b      <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            if (ALUOp == OP_MULU ||
                (ALUOp == OP_DIVU && !w_div0)) begin
              r_acc <= '0;
              r_q   <= A;
              r_b   <= B;
              r_cnt <= '0;
            end else if (ALUOp == OP_DIVU) begin
              r_hi     <= A;
              r_lo     <= '1;
              r_result <= '1;
              r_zero   <= 1'b0;
              r_done   <= 1'b1;
            end else begin
              r_result <= w_alu;
              r_zero   <= (w_alu == '0);
              r_done   <= 1'b1;
            end
          end
        end
        S_MUL: begin
          r_acc <= w_mhi;
          r_q   <= w_mlo;
          r_cnt <= r_cnt + 1'b1;
          if (w_last) begin
            r_hi     <= w_mhi;
            r_lo     <= w_mlo;
            r_result <= w_mlo;
            r_zero   <= (w_mlo == '0);
            r_done   <= 1'b1;
          end
        end
        S_DIV: begin
          r_acc <= w_drem;
          r_q   <= w_dq;
          r_cnt <= r_cnt + 1'b1;
          if (w_last) begin
            r_hi     <= w_drem;
            r_lo     <= w_dq;
            r_result <= w_dq;
            r_zero   <= (w_dq == '0);
            r_done   <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign result = r_result;
  assign zero   = r_zero;
  assign HI     = r_hi;
  assign LO     = r_lo;
  assign done   = r_done;
  assign busy   = (r_state != S_IDLE);

endmodule
